// File: rtl/bus_arbiter8.sv
// bus_arbiter8: round-robin arbiter for eight requesters sharing one mux8 datapath.
// It drives a one-hot grant and a binary mux select, and qualifies transfers with a
// valid/ready handshake. Each grant is capped at MAX_BURST beats. Every release
// inserts a single IDLE turnaround cycle before the next arbitration.
module bus_arbiter8 #(
    parameter int MAX_BURST = 4,   // beats per grant, 1..16
    parameter int CW        = 4    // beat counter width, 2**CW >= MAX_BURST
) (
    input  logic       clk,
    input  logic       n_reset,
    input  logic [7:0] req,
    input  logic       ready,
    output logic [7:0] gnt,
    output logic [2:0] sel,
    output logic       bus_valid,
    output logic       beat,
    output logic       busy
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [CW-1:0] LAST_BEAT = CW'(MAX_BURST - 1);

    state_t        state;
    logic [2:0]    ptr;       // highest-priority requester for the next arbitration
    logic [CW-1:0] cnt;       // beats accepted so far in the current grant
    logic [2:0]    winner;
    logic          found;
    logic [2:0]    scan_idx;
    logic          rel;

    // Rotating priority scan: the first requester at or after ptr, wrapping 7 -> 0.
    always_comb begin
        // NOTE: every variable assigned here gets a default first, so no path can
        // leave it unassigned and infer a latch.
        winner   = ptr;
        found    = 1'b0;
        scan_idx = ptr;
        for (int i = 0; i < 8; i++) begin
            scan_idx = ptr + 3'(i);
            if (!found && req[scan_idx]) begin
                winner = scan_idx;
                found  = 1'b1;
            end
        end
    end

    // Handshake qualification and grant-release decision.
    assign busy      = (state == GRANT);
    assign bus_valid = busy & req[sel];
    assign beat      = bus_valid & ready;
    assign rel       = !req[sel] || (beat && (cnt == LAST_BEAT));

    // Arbitration FSM; grant, select, pointer and beat count are all registered.
    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge n_reset) begin
        // NOTE: the reset branch is asynchronous and clears all state at once, so a
        // reset mid-burst drops the in-flight beat without keeping partial state.
        if (!n_reset) begin
            state <= IDLE;
            gnt   <= 8'h00;
            sel   <= 3'd0;
            ptr   <= 3'd0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        gnt   <= 8'(1) << winner;
                        sel   <= winner;
                        cnt   <= '0;
                        state <= GRANT;
                    end
                end
                GRANT: begin
                    if (rel) begin
                        // sel deliberately keeps its last value through IDLE.
                        gnt   <= 8'h00;
                        cnt   <= '0;
                        ptr   <= sel + 3'd1;
                        state <= IDLE;
                    end else if (beat) begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    gnt   <= 8'h00;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: doc/bus_arbiter8.md
Name: bus_arbiter8

Overview:
- Round-robin arbiter that shares one 8-input datapath mux (mux8) between 8 requesters feeding a single sink.
- It drives the mux select and a one-hot grant, qualifies transfers with a valid/ready handshake, and caps each grant to a burst length for fairness.
- It sits between requester blocks and the shared bus. The mux itself is instantiated outside this block.

Parameters:
- MAX_BURST, 4, maximum beats transferred per grant (legal range 1..16).
- CW, 4, width of the internal beat counter; must satisfy 2^CW >= MAX_BURST.

Ports:
- clk  input  1  system clock, rising edge
- n_reset  input  1  asynchronous active-low reset
- req  input  8  per-requester request; held high while the requester has beats to send
- ready  input  1  sink accepts a beat this cycle
- gnt  output  8  one-hot grant, registered
- sel  output  3  mux select (binary index of granted requester), registered
- bus_valid  output  1  beat present on bus = busy & req[sel], combinational
- beat  output  1  beat accepted this cycle = bus_valid & ready, combinational
- busy  output  1  high in GRANT state

Behaviour:
- Reset (n_reset low, asynchronous): state=IDLE, gnt=0, sel=0, busy=0, round-robin pointer ptr=0, beat count cnt=0. bus_valid and beat are therefore 0.
- Reset takes effect immediately, including mid-burst. An in-flight beat is dropped, with no partial state retained.
- States: IDLE and GRANT.
- IDLE:
  - gnt=0, busy=0.
  - If req!=0, pick the first set bit scanning ptr, ptr+1, ..., ptr+7 (mod 8).
  - Next edge: gnt<=onehot(winner), sel<=winner, cnt<=0, state<=GRANT.
  - Arbitration latency: 1 cycle from req high to gnt high.
  - If req==0, stay in IDLE.
- GRANT:
  - gnt and sel are held stable.
  - On each beat, cnt increments.
  - Release condition: (!req[sel]) OR (beat AND cnt==MAX_BURST-1).
  - On release, the next edge sets state<=IDLE, gnt<=0, cnt<=0, ptr<=sel+1 (mod 8). sel is held at its last value.
  - Every release inserts exactly one IDLE cycle before the next grant (deliberate bus turnaround).
  - A beat in the releasing cycle (burst limit reached) is a valid transfer.
  - If req[sel] drops, no beat occurs that cycle because bus_valid=0.
- Requests arriving while in GRANT are ignored until the next IDLE arbitration. No preemption.
- ready may toggle freely. With ready low, bus_valid stays high and cnt holds, with no timeout.
- Multiple simultaneous requests in IDLE: the winner is decided purely by ptr order, independent of arrival time.
- Wrap-around:
  - ptr=7 with a grant to 7 yields ptr=0 after release.
  - Scan order wraps 7 to 0.
- MAX_BURST=1: every beat releases the grant, so one beat per grant followed by one IDLE cycle.
- cnt never exceeds MAX_BURST-1. gnt is always zero or one-hot.

Test Plan:
- Reset and single requester: reset, then req=8'h04 held, ready=1. Expect gnt=8'h04 and sel=2 one cycle after req; 4 beats; release; IDLE 1 cycle; re-grant to 2 with ptr=3.
- All 8 requesting: req=8'hFF held, ready=1, from reset. Expect grant order 0,1,...,7,0, each with 4 beats separated by one IDLE cycle. gnt stays one-hot throughout.
- Backpressure: grant to requester 5, ready pattern 1,0,0,1,1,1. Expect beats only on ready-high cycles; release after the 4th beat; bus_valid stays 1 during the stall.
- Early drop: requester 3 granted, sends 2 beats, then deasserts req. Expect bus_valid=0 that cycle, then IDLE, ptr=4, and the next grant goes to requester 4 if req=8'h18.
- Wrap and late arrival: ptr=7, req=8'h81 arriving together. Expect grant to 7, then 0. A req[4] arriving mid-burst is not served until after the current grant releases.
- Async reset mid-burst: assert n_reset low between clock edges during beat 2 of a grant to 6. Expect gnt=0, sel=0, busy=0 immediately. After reset release with req=8'h40, expect a grant to 6 with a fresh 4-beat count.
